// File: rtl/block_io_unit.sv
// SRAM-side block I/O for the anchor sweep: fetches one COL_H-pixel column below the
// anchor, then writes the finished pixel X_OFFSET columns behind it and raises io_final.
module block_io_unit #(
    parameter int COL_H    = 4,
    parameter int PIX_W    = 8,
    parameter int X_OFFSET = 4
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   io_start,
    input  logic                   anchor_moving,
    input  logic [31:0]            anchor_x,
    input  logic [31:0]            anchor_y,
    input  logic [31:0]            width,
    input  logic [31:0]            height,
    input  logic [31:0]            read_base,
    input  logic [31:0]            write_base,
    input  logic                   read_enable,
    input  logic                   write_enable,
    input  logic [PIX_W-1:0]       result_pixel,
    input  logic                   mem_ready,
    input  logic [PIX_W-1:0]       mem_rdata,
    output logic [31:0]            mem_addr,
    output logic [PIX_W-1:0]       mem_wdata,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic [COL_H*PIX_W-1:0] col_data,
    output logic                   col_valid,
    output logic                   io_final
);

    localparam int ROW_W = (COL_H > 1) ? $clog2(COL_H) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(COL_H - 1);

    typedef enum logic [2:0] {IDLE, LATCH, READ, WRITE, DONE} state_t;

    state_t            state_reg, state_next;
    logic [31:0]       anchor_y_reg, anchor_y_next;
    logic              x_ok_reg, x_ok_next;
    logic              write_go_reg, write_go_next;
    logic [31:0]       write_addr_reg, write_addr_next;
    logic [PIX_W-1:0]  pixel_reg, pixel_next;
    logic [ROW_W-1:0]  row_idx_reg, row_idx_next;
    logic [31:0]       row_addr_reg, row_addr_next;
    logic [PIX_W-1:0]  col_rows_reg [COL_H];
    logic [PIX_W-1:0]  col_rows_next [COL_H];
    logic [31:0]       mem_addr_reg, mem_addr_next;
    logic [PIX_W-1:0]  mem_wdata_reg, mem_wdata_next;
    logic              mem_read_reg, mem_read_next;
    logic              mem_write_reg, mem_write_next;
    logic              col_valid_reg, col_valid_next;
    logic              io_final_reg, io_final_next;

    logic              start;
    logic [31:0]       base_off, wx, first_addr, write_addr_in, next_row_addr;
    logic              x_ok_in, write_go_in;
    logic [32:0]       next_y;
    logic              go_post, post_go;
    logic [31:0]       post_addr;
    logic [PIX_W-1:0]  post_pix;

    // Address arithmetic shared by the latch step and the row walk.
    always_comb begin
        start         = io_start | anchor_moving;
        base_off      = anchor_y * width;
        wx            = anchor_x - 32'(X_OFFSET);
        first_addr    = read_base + base_off + anchor_x;
        write_addr_in = write_base + base_off + wx;
        x_ok_in       = anchor_x < width;
        write_go_in   = write_enable && (anchor_x >= 32'(X_OFFSET)) && (wx < width)
                        && (anchor_y < height);
        next_y        = {1'b0, anchor_y_reg} + 33'(row_idx_reg) + 33'd1;
        next_row_addr = row_addr_reg + width;
    end

    always_comb begin
        state_next      = state_reg;
        anchor_y_next   = anchor_y_reg;
        x_ok_next       = x_ok_reg;
        write_go_next   = write_go_reg;
        write_addr_next = write_addr_reg;
        pixel_next      = pixel_reg;
        row_idx_next    = row_idx_reg;
        row_addr_next   = row_addr_reg;
        col_rows_next   = col_rows_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        mem_read_next   = mem_read_reg;
        mem_write_next  = mem_write_reg;
        col_valid_next  = 1'b0;
        io_final_next   = io_final_reg;
        go_post         = 1'b0;
        post_go         = 1'b0;
        post_addr       = '0;
        post_pix        = '0;

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next    = LATCH;
                    io_final_next = 1'b0;
                end
            end
            LATCH: begin
                anchor_y_next   = anchor_y;
                x_ok_next       = x_ok_in;
                write_go_next   = write_go_in;
                write_addr_next = write_addr_in;
                pixel_next      = result_pixel;
                row_idx_next    = '0;
                row_addr_next   = first_addr;
                if (read_enable) begin
                    state_next = READ;
                    if (x_ok_in && (anchor_y < height)) begin
                        mem_read_next = 1'b1;
                        mem_addr_next = first_addr;
                    end
                end else begin
                    // Read phase skipped: decide the write from the live inputs.
                    go_post   = 1'b1;
                    post_go   = write_go_in;
                    post_addr = write_addr_in;
                    post_pix  = result_pixel;
                end
            end
            READ: begin
                // A row without a strobe is a one-cycle zero pad.
                if (!mem_read_reg || mem_ready) begin
                    col_rows_next[row_idx_reg] = mem_read_reg ? mem_rdata : '0;
                    mem_read_next = 1'b0;
                    row_addr_next = next_row_addr;
                    if (row_idx_reg == LAST_ROW) begin
                        col_valid_next = 1'b1;
                        go_post        = 1'b1;
                        post_go        = write_go_reg;
                        post_addr      = write_addr_reg;
                        post_pix       = pixel_reg;
                    end else begin
                        row_idx_next = row_idx_reg + 1'b1;
                        if (x_ok_reg && (next_y < {1'b0, height})) begin
                            mem_read_next = 1'b1;
                            mem_addr_next = next_row_addr;
                        end
                    end
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    mem_write_next = 1'b0;
                    state_next     = DONE;
                    io_final_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (go_post) begin
            if (post_go) begin
                state_next     = WRITE;
                mem_write_next = 1'b1;
                mem_addr_next  = post_addr;
                mem_wdata_next = post_pix;
            end else begin
                state_next    = DONE;
                io_final_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg      <= IDLE;
            anchor_y_reg   <= '0;
            x_ok_reg       <= 1'b0;
            write_go_reg   <= 1'b0;
            write_addr_reg <= '0;
            pixel_reg      <= '0;
            row_idx_reg    <= '0;
            row_addr_reg   <= '0;
            for (int i = 0; i < COL_H; i++) col_rows_reg[i] <= '0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            col_valid_reg  <= 1'b0;
            io_final_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            anchor_y_reg   <= anchor_y_next;
            x_ok_reg       <= x_ok_next;
            write_go_reg   <= write_go_next;
            write_addr_reg <= write_addr_next;
            pixel_reg      <= pixel_next;
            row_idx_reg    <= row_idx_next;
            row_addr_reg   <= row_addr_next;
            col_rows_reg   <= col_rows_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            mem_read_reg   <= mem_read_next;
            mem_write_reg  <= mem_write_next;
            col_valid_reg  <= col_valid_next;
            io_final_reg   <= io_final_next;
        end
    end

    generate
        for (genvar gi = 0; gi < COL_H; gi++) begin : g_col
            assign col_data[gi*PIX_W +: PIX_W] = col_rows_reg[gi];
        end
    endgenerate

    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_read  = mem_read_reg;
    assign mem_write = mem_write_reg;
    assign col_valid = col_valid_reg;
    assign io_final  = io_final_reg;

endmodule
